io_interrupt_block: RTL

- Peripheral I/O stage directly upstream and downstream of the processor top level (main_module).
- Buffers bytes from an external producer in a small FIFO and presents the head byte on the processor's data_in bus.
- Raises the processor's interrupt input as a paced, acknowledged one-cycle pulse.
- Captures processor data_out bytes into a registered output port.

---
 rtl/io_interrupt_block.sv | 120 ++++++++++++
 1 files changed

// File: rtl/io_interrupt_block.sv
// I/O stage around the processor: byte FIFO feeding data_in with a paced,
// acknowledged interrupt pulse, plus a registered output port for data_out.
module io_interrupt_block #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned IRQ_HOLDOFF = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              ext_data,
  input  logic                    ext_valid,
  output logic                    ext_ready,
  input  logic                    cpu_rd,
  output logic [7:0]              data_in,
  output logic                    data_valid,
  output logic                    interrupt,
  input  logic                    irq_ack,
  input  logic                    cpu_wr,
  input  logic [7:0]              data_out,
  output logic [7:0]              port_out,
  output logic                    port_out_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    rd_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned HW = (IRQ_HOLDOFF > 1) ? $clog2(IRQ_HOLDOFF) : 1;
  localparam logic [AW:0]   DepthC   = (AW + 1)'(DEPTH);
  localparam logic [HW-1:0] HoldLoad = HW'(IRQ_HOLDOFF - 1);

  typedef enum logic [1:0] {StIdle, StAssert, StWaitAck, StHoldoff} state_e;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  logic          rd_err_q;
  logic [7:0]    port_out_q;
  logic          port_out_valid_q;
  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          interrupt_q;

  assign ext_ready  = (count_q < DepthC);
  assign data_valid = (count_q != '0);
  assign push       = ext_valid && ext_ready;
  assign pop        = cpu_rd && data_valid;
  assign data_in    = data_valid ? mem[rd_ptr_q] : 8'h00;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; data_in is masked to 8'h00 while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= ext_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      rd_err_q         <= 1'b0;
      port_out_q       <= 8'h00;
      port_out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (cpu_rd && !data_valid) rd_err_q <= 1'b1;
      if (cpu_wr) port_out_q <= data_out;
      port_out_valid_q <= cpu_wr;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle:    if (data_valid) state_d = StAssert;
      StAssert:  state_d = StWaitAck;
      StWaitAck: begin
        if (irq_ack) begin
          state_d = StHoldoff;
          hold_d  = HoldLoad;
        end
      end
      StHoldoff: begin
        if (hold_q == '0) state_d = StIdle;
        else              hold_d  = hold_q - 1'b1;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Interrupt comes from its own flop so the pulse is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      interrupt_q <= (state_d == StAssert);
    end
  end

  assign interrupt      = interrupt_q;
  assign port_out       = port_out_q;
  assign port_out_valid = port_out_valid_q;
  assign count          = count_q;
  assign rd_err         = rd_err_q;

endmodule
